// File: rtl/reg_file_ext.sv
// reg_file_ext: 3R1W register file with I2C byte port, status injection and committed PWM mirror; REG_FILE_BYPASS_EN enables write forwarding
module reg_file_ext #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int PWM_BASE = 8,
  parameter int PWM_CH   = 8,
  parameter int I2C_REG  = 6,
  parameter int STS_LSB  = 9,
  parameter int BSEL_W   = $clog2(DATA_W/8)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  input  logic [ADDR_W-1:0]        rd_addr_c,
  output logic [DATA_W-1:0]        rd_a,
  output logic [DATA_W-1:0]        rd_b,
  output logic [DATA_W-1:0]        rd_c,
  input  logic                     i2c_req,
  input  logic                     i2c_we,
  input  logic [ADDR_W-1:0]        i2c_reg,
  input  logic [BSEL_W-1:0]        i2c_bsel,
  input  logic [7:0]               i2c_wdata,
  output logic [7:0]               i2c_rdata,
  output logic                     i2c_ack,
  input  logic                     i2c_sts_we,
  input  logic [1:0]               i2c_sts,
  output logic [8:0]               i2c_addr,
  input  logic                     pwm_commit,
  output logic [PWM_CH*DATA_W-1:0] pwm_bus,
  output logic                     pwm_updated
);
  localparam int DEPTH = 2**ADDR_W;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              l_we;
  logic [ADDR_W-1:0] l_reg;
  logic [BSEL_W-1:0] l_bsel;
  logic [7:0]        l_wdata;
  logic [BSEL_W+2:0] l_off;
  assign l_off = {l_bsel, 3'b000};
  assign rd_a = (BYP && wr_en && rd_addr_a == wr_addr && |rd_addr_a) ? wr_data : regs[rd_addr_a];
  assign rd_b = (BYP && wr_en && rd_addr_b == wr_addr && |rd_addr_b) ? wr_data : regs[rd_addr_b];
  assign rd_c = (BYP && wr_en && rd_addr_c == wr_addr && |rd_addr_c) ? wr_data : regs[rd_addr_c];
  assign i2c_addr = regs[I2C_REG][8:0];
  assign i2c_ack  = (state == ACK);
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)   ? (i2c_req ? ACCESS : IDLE) :
               (state == ACCESS) ? ACK :
               (i2c_req ? ACK : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      l_we      <= 1'b0;
      l_reg     <= '0;
      l_bsel    <= '0;
      l_wdata   <= '0;
      i2c_rdata <= '0;
    end else begin
      if (state == IDLE && i2c_req) begin
        l_we    <= i2c_we;
        l_reg   <= i2c_reg;
        l_bsel  <= i2c_bsel;
        l_wdata <= i2c_wdata;
      end
      if (state == ACCESS && !l_we) i2c_rdata <= regs[l_reg][l_off +: 8];
    end
  // later non-blocking writes override earlier ones: I2C byte < core word < status bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (state == ACCESS && l_we && |l_reg) regs[l_reg][l_off +: 8] <= l_wdata;
      if (wr_en && |wr_addr) regs[wr_addr] <= wr_data;
      if (i2c_sts_we && I2C_REG != 0) regs[I2C_REG][STS_LSB +: 2] <= i2c_sts;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pwm_updated <= 1'b0;
    else        pwm_updated <= pwm_commit;
  for (genvar k = 0; k < PWM_CH; k++) begin : g_pwm
    logic [DATA_W-1:0] shadow;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)          shadow <= '0;
      else if (pwm_commit) shadow <= regs[PWM_BASE + k];
    assign pwm_bus[k*DATA_W +: DATA_W] = shadow;
  end
endmodule

// File: tb/tb_reg_file_ext.sv
// tb_reg_file_ext: directed self-checking bench for reg_file_ext (honours REG_FILE_BYPASS_EN)
module tb_reg_file_ext;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [15:0]  wr_data = '0;
  logic [3:0]   rd_addr_a = '0, rd_addr_b = '0, rd_addr_c = '0;
  logic [15:0]  rd_a, rd_b, rd_c;
  logic         i2c_req = 1'b0, i2c_we = 1'b0;
  logic [3:0]   i2c_reg = '0;
  logic [0:0]   i2c_bsel = '0;
  logic [7:0]   i2c_wdata = '0, i2c_rdata;
  logic         i2c_ack;
  logic         i2c_sts_we = 1'b0;
  logic [1:0]   i2c_sts = '0;
  logic [8:0]   i2c_addr;
  logic         pwm_commit = 1'b0;
  logic [127:0] pwm_bus;
  logic         pwm_updated;
  int checks = 0;
  int failures = 0;
  reg_file_ext dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c),
    .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_reg(i2c_reg), .i2c_bsel(i2c_bsel),
    .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata), .i2c_ack(i2c_ack),
    .i2c_sts_we(i2c_sts_we), .i2c_sts(i2c_sts), .i2c_addr(i2c_addr),
    .pwm_commit(pwm_commit), .pwm_bus(pwm_bus), .pwm_updated(pwm_updated)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic core_wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] exp);
    rd_addr_a = a;
    #1;
    chk(tag, rd_a, exp);
  endtask
  // full handshake; optional core write / status injection land on the access edge E1
  task automatic i2c_xfer(input logic we, input logic [3:0] r, input logic b, input logic [7:0] d,
                          input logic cwe, input logic [15:0] cd, input logic swe, input logic [1:0] s);
    i2c_we = we; i2c_reg = r; i2c_bsel = b; i2c_wdata = d; i2c_req = 1'b1;
    tick;
    chk("ack_e0", i2c_ack, 0);
    wr_en = cwe; wr_addr = r; wr_data = cd; i2c_sts_we = swe; i2c_sts = s;
    tick;
    wr_en = 1'b0; i2c_sts_we = 1'b0;
    chk("ack_e1", i2c_ack, 1);
    tick;
    chk("ack_hold", i2c_ack, 1);
    i2c_req = 1'b0;
    tick;
    chk("ack_fall", i2c_ack, 0);
  endtask
  initial begin
    tick;
    tick;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i); rd_addr_c = 4'(i);
      #1;
      chk("rst_rd", {rd_a, rd_b}, 0);
      chk("rst_rdc", rd_c, 0);
    end
    chk("rst_pwm", pwm_bus[31:0], 0);
    chk("rst_pwm_hi", pwm_bus[127:96], 0);
    chk("rst_ack", i2c_ack, 0);
    chk("rst_upd", pwm_updated, 0);
    rst_n = 1'b1;
    tick;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF; rd_addr_a = 4'd3;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("pre_edge_rd", rd_a, 16'hBEEF);
`else
    chk("pre_edge_rd", rd_a, 16'h0000);
`endif
    tick;
    wr_en = 1'b0;
    rd_addr_a = 4'd3; rd_addr_b = 4'd3; rd_addr_c = 4'd0;
    #1;
    chk("core_a", rd_a, 16'hBEEF);
    chk("core_b", rd_b, 16'hBEEF);
    chk("core_c", rd_c, 16'h0000);
    core_wr(4'd0, 16'hFFFF);
    rd("reg0", 4'd0, 16'h0000);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h00AA; rd_addr_a = 4'd2;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("bypass", rd_a, 16'h00AA);
`else
    chk("bypass", rd_a, 16'h0000);
`endif
    tick;
    wr_en = 1'b0;
    rd("reg2", 4'd2, 16'h00AA);
    i2c_xfer(1'b1, 4'd6, 1'b1, 8'h5A, 1'b0, 16'h0, 1'b1, 2'b11);
    rd("i2c_sts_wr", 4'd6, 16'h5E00);
    i2c_xfer(1'b0, 4'd3, 1'b1, 8'h00, 1'b0, 16'h0, 1'b0, 2'b00);
    chk("i2c_rd_hi", i2c_rdata, 8'hBE);
    i2c_xfer(1'b0, 4'd3, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 2'b00);
    chk("i2c_rd_lo", i2c_rdata, 8'hEF);
    i2c_xfer(1'b1, 4'd9, 1'b0, 8'hFF, 1'b1, 16'h1234, 1'b0, 2'b00);
    rd("core_beats_i2c", 4'd9, 16'h1234);
    i2c_xfer(1'b0, 4'd9, 1'b0, 8'h00, 1'b1, 16'hABCD, 1'b0, 2'b00);
    chk("i2c_rd_preedge", i2c_rdata, 8'h34);
    core_wr(4'd6, 16'h01A5);
    chk("i2c_addr", i2c_addr, 9'h1A5);
    i2c_sts_we = 1'b1; i2c_sts = 2'b10;
    tick;
    i2c_sts_we = 1'b0;
    rd("sts_inject", 4'd6, 16'h05A5);
    chk("i2c_addr_sts", i2c_addr, 9'h1A5);
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h0000; i2c_sts_we = 1'b1; i2c_sts = 2'b01;
    tick;
    wr_en = 1'b0; i2c_sts_we = 1'b0;
    rd("sts_beats_core", 4'd6, 16'h0200);
    i2c_req = 1'b1; i2c_we = 1'b1; i2c_reg = 4'd7; i2c_bsel = 1'b0; i2c_wdata = 8'h11;
    tick;
    i2c_req = 1'b0;
    tick;
    chk("drop_ack", i2c_ack, 1);
    tick;
    chk("drop_idle", i2c_ack, 0);
    rd("drop_wr", 4'd7, 16'h0011);
    core_wr(4'd8, 16'h0400);
    core_wr(4'd15, 16'hCAFE);
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 16'h0800; pwm_commit = 1'b1;
    tick;
    wr_en = 1'b0; pwm_commit = 1'b0;
    chk("pwm_ch0", pwm_bus[15:0], 16'h0400);
    chk("pwm_ch7", pwm_bus[127:112], 16'hCAFE);
    chk("pwm_upd", pwm_updated, 1);
    tick;
    chk("pwm_upd_off", pwm_updated, 0);
    chk("pwm_hold", pwm_bus[15:0], 16'h0400);
    pwm_commit = 1'b1;
    tick;
    chk("pwm_ch0_2", pwm_bus[15:0], 16'h0800);
    chk("pwm_upd_b2b1", pwm_updated, 1);
    tick;
    pwm_commit = 1'b0;
    chk("pwm_upd_b2b2", pwm_updated, 1);
    tick;
    chk("pwm_upd_end", pwm_updated, 0);
    i2c_we = 1'b0; i2c_reg = 4'd3; i2c_bsel = 1'b1; i2c_req = 1'b1;
    tick;
    tick;
    chk("pre_rst_ack", i2c_ack, 1);
    chk("pre_rst_rdata", i2c_rdata, 8'hBE);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack_async", i2c_ack, 0);
    chk("rst_rdata", i2c_rdata, 0);
    chk("rst_pwm2", pwm_bus[15:0], 0);
    chk("rst_i2c_addr", i2c_addr, 0);
    rd("rst_reg3", 4'd3, 16'h0000);
    rd("rst_reg8", 4'd8, 16'h0000);
    tick;
    chk("rst_hold_ack", i2c_ack, 0);
    i2c_req = 1'b0;
    rst_n = 1'b1;
    tick;
    chk("post_rst_idle", i2c_ack, 0);
    i2c_xfer(1'b1, 4'd5, 1'b0, 8'h77, 1'b0, 16'h0, 1'b0, 2'b00);
    rd("post_rst_wr", 4'd5, 16'h0077);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
